// File: rtl/aesl_deadlock_pkg.sv
// Shared defaults and helpers for the kernel deadlock monitor.
// Constants only; no logic, no latency.
package aesl_deadlock_pkg;

   localparam int DEF_AXIS_NUM     = 4;
   localparam int DEF_IDLE_NUM     = 4;
   localparam int DEF_INST_NUM     = 1;
   localparam int DEF_STALL_CYCLES = 4;

   // Counter must be able to hold STALL_CYCLES itself (the saturation value).
   function automatic int cnt_width(input int stall_cycles);
      return $clog2(stall_cycles + 1);
   endfunction

endpackage

// File: rtl/aesl_deadlock_stall_cnt.sv
// Saturating stall counter with threshold compare; block is registered and rises
// STALL_CYCLES edges after stall rises. Sticky behaviour under AESL_DEADLOCK_STICKY_EN.
module aesl_deadlock_stall_cnt
   import aesl_deadlock_pkg::*;
#(
   parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_stall,
   output logic o_block
);

   localparam int            CW  = cnt_width(STALL_CYCLES);
   localparam logic [CW-1:0] SAT = CW'(STALL_CYCLES);
   localparam logic [CW-1:0] ARM = CW'(STALL_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_block;
   logic          w_hit;

   // Once saturated the count sits at SAT, so both values keep block asserted.
   assign w_hit = i_stall && ((r_cnt == ARM) || (r_cnt == SAT));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_block <= 1'b0;
      end else begin
         if (!i_stall)
            r_cnt <= '0;
         else if (r_cnt != SAT)
            r_cnt <= r_cnt + 1'b1;
`ifdef AESL_DEADLOCK_STICKY_EN
         r_block <= r_block | w_hit;
`else
         r_block <= w_hit;
`endif
      end
   end

   assign o_block = r_block;

endmodule

// File: rtl/aesl_deadlock_idx0_monitor.sv
// Kernel deadlock monitor: flags block when some port/instance is blocked while the
// kernel is not fully idle for STALL_CYCLES edges. Optional macro: AESL_DEADLOCK_STICKY_EN.
module aesl_deadlock_idx0_monitor
   import aesl_deadlock_pkg::*;
#(
   parameter int AXIS_NUM     = DEF_AXIS_NUM,
   parameter int IDLE_NUM     = DEF_IDLE_NUM,
   parameter int INST_NUM     = DEF_INST_NUM,
   parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [AXIS_NUM-1:0] axis_block_sigs,
   input  logic [IDLE_NUM-1:0] inst_idle_sigs,
   input  logic [INST_NUM-1:0] inst_block_sigs,
   output logic                block
);

   logic w_any_blk;
   logic w_all_idle;
   logic w_stall;

   // A fully idle kernel has finished, so blocked handshakes there are not a deadlock.
   assign w_any_blk  = (|axis_block_sigs) | (|inst_block_sigs);
   assign w_all_idle = &inst_idle_sigs;
   assign w_stall    = w_any_blk & ~w_all_idle;

   aesl_deadlock_stall_cnt #(
      .STALL_CYCLES (STALL_CYCLES)
   ) u_stall_cnt (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_stall (w_stall),
      .o_block (block)
   );

endmodule

// File: tb/tb_aesl_deadlock_idx0_monitor.sv
// Directed bench for the deadlock monitor (default parameters, STALL_CYCLES = 4).
module tb_aesl_deadlock_idx0_monitor;

   logic       clock;
   logic       reset;
   logic [3:0] axis_block_sigs;
   logic [3:0] inst_idle_sigs;
   logic [0:0] inst_block_sigs;
   logic       block;

   int errors = 0;
   int checks = 0;

`ifdef AESL_DEADLOCK_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   aesl_deadlock_idx0_monitor dut (
      .clock           (clock),
      .reset           (reset),
      .axis_block_sigs (axis_block_sigs),
      .inst_idle_sigs  (inst_idle_sigs),
      .inst_block_sigs (inst_block_sigs),
      .block           (block)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      axis_block_sigs = 4'b0000;
      inst_idle_sigs  = 4'b0000;
      inst_block_sigs = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      clear_inputs();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      for (int e = 1; e <= 3; e++) begin
         step();
         checks++;
         if (block !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold edge %0d: block=%b expected 0", e, block);
         end
      end
      reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         step();
         checks++;
         if (block !== 1'b0) begin
            errors++;
            $display("FAIL reset_release edge %0d: block=%b expected 0", e, block);
         end
      end
   endtask

   task automatic test_single_port();
      logic exp;
      apply_reset();
      axis_block_sigs = 4'b0100;
      inst_idle_sigs  = 4'b0000;
      for (int e = 1; e <= 8; e++) begin
         step();
         exp = (e >= 4);
         checks++;
         if (block !== exp) begin
            errors++;
            $display("FAIL single_port edge %0d: block=%b expected %b", e, block, exp);
         end
      end
   endtask

   task automatic test_restart();
      logic exp;
      apply_reset();
      axis_block_sigs = 4'b0001;
      for (int e = 1; e <= 3; e++) begin
         step();
         checks++;
         if (block !== 1'b0) begin
            errors++;
            $display("FAIL restart_pre edge %0d: block=%b expected 0", e, block);
         end
      end
      axis_block_sigs = 4'b0000;
      step();
      checks++;
      if (block !== 1'b0) begin
         errors++;
         $display("FAIL restart_gap: block=%b expected 0", block);
      end
      axis_block_sigs = 4'b0001;
      for (int e = 1; e <= 5; e++) begin
         step();
         exp = (e >= 4);
         checks++;
         if (block !== exp) begin
            errors++;
            $display("FAIL restart_post edge %0d: block=%b expected %b", e, block, exp);
         end
      end
   endtask

   task automatic test_idle_mask();
      apply_reset();
      inst_block_sigs = 1'b1;
      inst_idle_sigs  = 4'b1111;
      for (int e = 1; e <= 10; e++) begin
         step();
         checks++;
         if (block !== 1'b0) begin
            errors++;
            $display("FAIL idle_mask edge %0d: block=%b expected 0", e, block);
         end
      end
   endtask

   task automatic test_multi_bits();
      logic exp;
      apply_reset();
      axis_block_sigs = 4'b1111;
      inst_block_sigs = 1'b1;
      inst_idle_sigs  = 4'b0111;
      for (int e = 1; e <= 20; e++) begin
         step();
         exp = (e >= 4);
         checks++;
         if (block !== exp) begin
            errors++;
            $display("FAIL multi_bits edge %0d: block=%b expected %b", e, block, exp);
         end
      end
   endtask

   task automatic test_mid_stall_reset();
      logic exp;
      apply_reset();
      axis_block_sigs = 4'b0010;
      for (int e = 1; e <= 3; e++) step();
      reset = 1'b1;
      step();
      checks++;
      if (block !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: block=%b expected 0", block);
      end
      reset = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         exp = (e >= 4);
         checks++;
         if (block !== exp) begin
            errors++;
            $display("FAIL mid_reset_resume edge %0d: block=%b expected %b", e, block, exp);
         end
      end
   endtask

   task automatic test_release();
      apply_reset();
      axis_block_sigs = 4'b1000;
      for (int e = 1; e <= 4; e++) step();
      checks++;
      if (block !== 1'b1) begin
         errors++;
         $display("FAIL release_set: block=%b expected 1", block);
      end
      clear_inputs();
      for (int e = 1; e <= 3; e++) begin
         step();
         checks++;
         if (block !== STICKY) begin
            errors++;
            $display("FAIL release_drop edge %0d: block=%b expected %b", e, block, STICKY);
         end
      end
      reset = 1'b1;
      step();
      checks++;
      if (block !== 1'b0) begin
         errors++;
         $display("FAIL release_reset: block=%b expected 0", block);
      end
      reset = 1'b0;
      step();
      checks++;
      if (block !== 1'b0) begin
         errors++;
         $display("FAIL release_after_reset: block=%b expected 0", block);
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_single_port();
      test_restart();
      test_idle_mask();
      test_multi_bits();
      test_mid_stall_reset();
      test_release();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aesl_deadlock_idx0_monitor.md
AESL_DEADLOCK_IDX0_MONITOR -- requirements
Module: aesl_deadlock_idx0_monitor

Interface
REQ-001 SHALL have parameter AXIS_NUM, default 4: number of AXI-stream block inputs.
REQ-002 SHALL have parameter IDLE_NUM, default 4: number of instance idle inputs.
REQ-003 SHALL have parameter INST_NUM, default 1: number of instance block inputs.
REQ-004 SHALL have parameter STALL_CYCLES, default 4, legal range 1..255: consecutive stalled cycles required before block asserts.
REQ-005 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port axis_block_sigs  input  AXIS_NUM: bit i high = stream port i is waiting on its external partner.
REQ-008 SHALL have port inst_idle_sigs  input  IDLE_NUM: bit i high = sub-instance i is idle.
REQ-009 SHALL have port inst_block_sigs  input  INST_NUM: bit i high = instance i is blocked internally.
REQ-010 SHALL have port block  output  1: registered kernel-deadlock flag.

Function
REQ-011 SHALL compute any_blk = OR of all axis_block_sigs bits OR all inst_block_sigs bits.
REQ-012 SHALL compute all_idle = AND of all inst_idle_sigs bits.
REQ-013 SHALL compute stall_cond = any_blk AND NOT all_idle (a fully idle kernel is finished, not deadlocked).
REQ-014 SHALL hold a counter, width clog2(STALL_CYCLES+1), incremented on each edge with stall_cond high and saturating at STALL_CYCLES.
REQ-015 SHALL clear the counter to 0 on any edge where stall_cond is low.
REQ-016 SHALL set block high on the edge where stall_cond is high and the counter already equals STALL_CYCLES-1, i.e. block rises exactly STALL_CYCLES edges after stall_cond rises and stays continuously high.
REQ-017 SHALL treat a one-cycle drop of stall_cond as a full restart: the count begins again from 0.
REQ-018 SHALL treat simultaneous assertion of several block bits identically to one bit; no per-port state is kept.
REQ-019 SHALL drive block purely from registers; no combinational path from inputs to block.

Reset
REQ-020 SHALL, on any edge with reset high, clear the counter and block to 0, overriding stall_cond and the latched state.
REQ-021 SHALL resume counting on the first edge with reset low; reset mid-stall restarts the full STALL_CYCLES window.

Configuration
REQ-022 SHALL, with macro AESL_DEADLOCK_STICKY_EN defined, latch block high once set until reset, regardless of stall_cond.
REQ-023 SHALL, without AESL_DEADLOCK_STICKY_EN, clear block on the edge after stall_cond is sampled low.

Structure
REQ-024 SHALL place default parameter constants (AXIS_NUM, IDLE_NUM, INST_NUM, STALL_CYCLES) and the counter-width function in a shared package aesl_deadlock_pkg.
REQ-025 SHALL implement the saturating counter plus threshold compare as one sub-module aesl_deadlock_stall_cnt; reduction logic stays in the top.

Verification
REQ-026 SHALL check: reset high 3 cycles, all inputs 0 -> block 0 throughout and after reset release.
REQ-027 SHALL check: axis_block_sigs=4'b0100, inst_idle_sigs=4'b0000 held -> block 0 for edges 1..3, 1 from edge 4 onward.
REQ-028 SHALL check: axis_block_sigs=4'b0001 for 3 edges, 0 for 1 edge, then 4'b0001 again -> block rises only 4 edges after the restart.
REQ-029 SHALL check: inst_block_sigs=1, inst_idle_sigs=4'b1111 for 10 edges -> block stays 0.
REQ-030 SHALL check: block high, then all blocking inputs drop -> with STICKY_EN block stays 1; without it block 0 on next edge; reset high -> block 0 on next edge in both builds.
